// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the data memory. The CPU port has fixed priority and the
// debug/DMA port has bounded starvation. One transaction is in flight at a time: ACCESS, then RESP.
module dmem_arbiter #(
    parameter int unsigned DEPTH      = 1025,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    output logic        p0_gnt,
    output logic        p0_rvalid,
    output logic [31:0] p0_rdata,
    output logic        p0_err,

    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p1_gnt,
    output logic        p1_rvalid,
    output logic [31:0] p1_rdata,
    output logic        p1_err,

    output logic [31:0] mwaddr,
    output logic [31:0] wdata,
    output logic        mwe,
    output logic [31:0] mraddr,
    output logic        mre,
    input  logic [31:0] mrdata
);

    localparam int unsigned   SW         = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [31:0]   DEPTH_W    = 32'(DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          cmd_id_q, cmd_id_d;
    logic          cmd_we_q, cmd_we_d;
    logic          cmd_err_q, cmd_err_d;
    logic [31:0]   cmd_addr_q, cmd_addr_d;
    logic [31:0]   cmd_wdata_q, cmd_wdata_d;
    logic [31:0]   rdata_q, rdata_d;

    logic          any_req;
    logic          both_req;
    logic          p1_wins;
    logic [31:0]   sel_addr;
    logic          mem_active;
    logic          mem_we;
    logic          mem_re;

    assign any_req  = p0_req | p1_req;
    assign both_req = p0_req & p1_req;
    // Port 1 takes a contended slot only once it has lost STARVE_MAX of them in a row.
    assign p1_wins  = p1_req & (~p0_req | (starve_q == STARVE_LIM));
    assign sel_addr = p1_wins ? p1_addr : p0_addr;

    assign mem_active = (state_q == ACCESS);
    assign mem_we     = mem_active & cmd_we_q & ~cmd_err_q;
    assign mem_re     = mem_active & ~cmd_we_q & ~cmd_err_q;

    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        cmd_id_d    = cmd_id_q;
        cmd_we_d    = cmd_we_q;
        cmd_err_d   = cmd_err_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        rdata_d     = rdata_q;

        case (state_q)
            IDLE, RESP: begin
                if (any_req) begin
                    state_d     = ACCESS;
                    cmd_id_d    = p1_wins;
                    cmd_we_d    = p1_wins ? p1_we : p0_we;
                    cmd_addr_d  = sel_addr;
                    cmd_wdata_d = p1_wins ? p1_wdata : p0_wdata;
                    cmd_err_d   = (sel_addr >= DEPTH_W);
                    if (p1_wins) begin
                        starve_d = '0;
                    end else if (both_req && (starve_q != STARVE_LIM)) begin
                        starve_d = starve_q + SW'(1);
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                state_d = RESP;
                rdata_d = mem_re ? mrdata : '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            starve_q    <= '0;
            cmd_id_q    <= 1'b0;
            cmd_we_q    <= 1'b0;
            cmd_err_q   <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            cmd_id_q    <= cmd_id_d;
            cmd_we_q    <= cmd_we_d;
            cmd_err_q   <= cmd_err_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
            rdata_q     <= rdata_d;
        end
    end

    logic [1:0]  gnt_v;
    logic [1:0]  rvalid_v;
    logic [1:0]  err_v;
    logic [31:0] rdata_v [2];

    // Response outputs stay zero for the port that does not own the current command.
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        logic mine;
        assign mine         = (cmd_id_q == 1'(gi));
        assign gnt_v[gi]    = mem_active & mine;
        assign rvalid_v[gi] = (state_q == RESP) & mine;
        assign err_v[gi]    = rvalid_v[gi] & cmd_err_q;
        assign rdata_v[gi]  = rvalid_v[gi] ? rdata_q : '0;
    end

    assign p0_gnt    = gnt_v[0];
    assign p0_rvalid = rvalid_v[0];
    assign p0_err    = err_v[0];
    assign p0_rdata  = rdata_v[0];
    assign p1_gnt    = gnt_v[1];
    assign p1_rvalid = rvalid_v[1];
    assign p1_err    = err_v[1];
    assign p1_rdata  = rdata_v[1];

    assign mwe    = mem_we;
    assign mre    = mem_re;
    assign mwaddr = mem_active ? cmd_addr_q : '0;
    assign mraddr = mem_active ? cmd_addr_q : '0;
    assign wdata  = mem_active ? cmd_wdata_q : '0;

endmodule
